// File: rtl/multi_digit_display.sv
// Multiplexed seven-segment driver: binary value shown in hex or decimal (double-dabble
// conversion), with leading-zero blanking, overflow dashes and per-digit decimal points.
module multi_digit_display #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned VALUE_WIDTH = 16,
    parameter int unsigned REFRESH_DIV = 1000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [VALUE_WIDTH-1:0] value,
    input  logic                   load,
    input  logic                   hex_mode,
    input  logic                   blank_lz,
    input  logic [DIGITS-1:0]      dp_mask,
    output logic [7:0]             sseg,
    output logic [DIGITS-1:0]      digits,
    output logic                   busy,
    output logic                   overflow
);

    // Decimal digits needed to hold 2^w-1.
    function automatic int unsigned calc_bcd_digits(int unsigned w);
        longint unsigned m;
        int unsigned     n;
        m = (64'd1 << w) - 64'd1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (m != 64'd0) begin
                n++;
                m = m / 64'd10;
            end
        end
        return (n == 0) ? 1 : n;
    endfunction

    localparam int unsigned BCD_DIGITS = calc_bcd_digits(VALUE_WIDTH);
    localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
    localparam int unsigned PAD_W      = 4 * DIGITS + VALUE_WIDTH + BCD_W;
    localparam int unsigned CNT_W      = $clog2(VALUE_WIDTH);
    localparam int unsigned PRE_W      = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W      = $clog2(DIGITS);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    function automatic logic [6:0] seg_code(logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    typedef enum logic [0:0] {StIdle, StConv} state_e;

    state_e                 state_q;
    logic                   busy_q;
    logic                   overflow_q;
    logic                   hex_q;
    logic                   blank_q;
    logic [VALUE_WIDTH-1:0] bin_q;
    logic [BCD_W-1:0]       bcd_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [6:0]             buf_q [DIGITS];

    logic [PRE_W-1:0]       presc_q;
    logic [IDX_W-1:0]       idx_q;
    logic [7:0]             sseg_q;
    logic [DIGITS-1:0]      digits_q;

    logic [BCD_W-1:0]       bcd_adj;
    logic [BCD_W-1:0]       bcd_next;
    logic [PAD_W-1:0]       src;
    logic                   ovf;
    logic                   lead;
    logic [3:0]             dig;
    logic [6:0]             new_buf [DIGITS];
    logic                   tick;

    // One double-dabble step: add 3 to any BCD digit >= 5, then shift in the next MSB.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(BCD_DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_next = {bcd_adj[BCD_W-2:0], bin_q[VALUE_WIDTH-1]};
    end

    // Display buffer contents to commit when the conversion finishes.
    always_comb begin
        src  = hex_q ? PAD_W'(bin_q) : PAD_W'(bcd_next);
        ovf  = |(src >> (4 * DIGITS));
        lead = 1'b1;
        dig  = 4'd0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            dig  = src[4*i +: 4];
            lead = lead && (dig == 4'd0);
            if (ovf) begin
                new_buf[i] = SEG_DASH;
            end else if (blank_q && lead && (i != 0)) begin
                new_buf[i] = SEG_BLANK;
            end else begin
                new_buf[i] = seg_code(dig);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            hex_q      <= 1'b0;
            blank_q    <= 1'b0;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < int'(DIGITS); i++) begin
                buf_q[i] <= SEG_BLANK;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (load) begin
                        state_q <= StConv;
                        busy_q  <= 1'b1;
                        bin_q   <= value;
                        hex_q   <= hex_mode;
                        blank_q <= blank_lz;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                StConv: begin
                    if (!hex_q) begin
                        bcd_q <= bcd_next;
                        bin_q <= bin_q << 1;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    if (hex_q || (cnt_q == CNT_W'(VALUE_WIDTH - 1))) begin
                        buf_q      <= new_buf;
                        overflow_q <= ovf;
                        busy_q     <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign tick = (presc_q == PRE_W'(REFRESH_DIV - 1));

    // Scan reads buf_q before any same-cycle commit, so a coincident tick shows old data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            presc_q  <= '0;
            idx_q    <= '0;
            sseg_q   <= 8'hFF;
            digits_q <= '0;
        end else if (tick) begin
            presc_q  <= '0;
            digits_q <= DIGITS'(1) << idx_q;
            sseg_q   <= {~dp_mask[idx_q], buf_q[idx_q]};
            idx_q    <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end else begin
            presc_q <= presc_q + PRE_W'(1);
        end
    end

    assign sseg     = sseg_q;
    assign digits   = digits_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule
